// File: rtl/b16_loom_bitser_feed_pkg.sv
// Shared constants, state encoding and helpers for the Loom bit-serial feed.
package b16_loom_pkg;

  localparam int unsigned LANES  = 16;
  localparam int unsigned ACT_W  = 16;
  localparam int unsigned WGT_W  = 16;
  localparam int unsigned PSUM_W = 20;
  localparam int unsigned PREC_W = 5;
  localparam int unsigned BIDX_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Plain-vector state constants for the FSM register
  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_RUN  = RUN;

  // Out-of-range precision (0 or above 16) runs at the full 16 bits
  function automatic logic [PREC_W-1:0] eff_prec(input logic [PREC_W-1:0] p);
    return ((p == '0) || (p > PREC_W'(16))) ? PREC_W'(16) : p;
  endfunction

endpackage

// File: rtl/b16_loom_bitser_feed_if.sv
// Vector-in / bit-plane-out bus between upstream, the feed block and the accumulator.
interface b16_loom_bitser_feed_if;
  import b16_loom_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*ACT_W-1:0]   act_flat;
  logic [LANES*WGT_W-1:0]   wgt_flat;
  logic [PREC_W-1:0]        prec;
  logic [PSUM_W-1:0]        psum;
  logic                     sign;
  logic                     sel;
  logic                     done;
  logic                     busy;

  modport slave (
    input  in_valid, act_flat, wgt_flat, prec,
    output in_ready, psum, sign, sel, done, busy
  );

  modport master (
    output in_valid, act_flat, wgt_flat, prec,
    input  in_ready, psum, sign, sel, done, busy
  );

endinterface

// File: rtl/b16_loom_bitser_feed_psum_tree.sv
// Combinational AND-gate + adder tree: sum of activations whose plane bit is set.
module b16_loom_psum_tree
  import b16_loom_pkg::*;
(
  input  logic [LANES*ACT_W-1:0] i_act_flat,
  input  logic [LANES-1:0]       i_plane,
  output logic [PSUM_W-1:0]      o_sum_c
);

  // Gate each lane by its plane bit and accumulate zero-extended
  always_comb begin
    o_sum_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (i_plane[i]) begin
        o_sum_c = o_sum_c + PSUM_W'(i_act_flat[i*ACT_W +: ACT_W]);
      end
    end
  end

endmodule

// File: rtl/b16_loom_bitser_feed.sv
// Bit-serial weight feed for the Loom shift-accumulator: serializes weights
// MSB-first and presents one registered bit-plane partial sum per cycle.
// Optional macro LOOM_SIGNED_WGT_EN: two's-complement weights, sign flags the MSB plane.
module b16_loom_bitser_feed
  import b16_loom_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  b16_loom_bitser_feed_if.slave bus
);

  logic [0:0]             r_state,  w_state_nxt;
  logic [BIDX_W-1:0]      r_bidx,   w_bidx_nxt;
  logic [LANES*ACT_W-1:0] r_act,    w_act_nxt;
  logic [LANES*WGT_W-1:0] r_wgt,    w_wgt_nxt;
  logic                   w_accept;
  logic [LANES-1:0]       w_plane;
  logic [PSUM_W-1:0]      w_sum;

  logic [PSUM_W-1:0]      r_psum;
  logic                   r_sel;
  logic                   r_done;
  logic                   r_busy;
  logic                   r_in_ready;

  assign w_accept = bus.in_valid && r_in_ready;

  // FSM state and operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_bidx  <= '0;
      r_act   <= '0;
      r_wgt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bidx  <= w_bidx_nxt;
      r_act   <= w_act_nxt;
      r_wgt   <= w_wgt_nxt;
    end
  end

  // Next state: load on accept, otherwise walk the bit index down to zero
  always_comb begin
    w_state_nxt = r_state;
    w_bidx_nxt  = r_bidx;
    w_act_nxt   = r_act;
    w_wgt_nxt   = r_wgt;
    if (w_accept) begin
      w_state_nxt = ST_RUN;
      w_bidx_nxt  = BIDX_W'(eff_prec(bus.prec) - PREC_W'(1));
      w_act_nxt   = bus.act_flat;
      w_wgt_nxt   = bus.wgt_flat;
    end else if (r_state == ST_RUN) begin
      if (r_bidx == '0) begin
        w_state_nxt = ST_IDLE;
      end else begin
        w_bidx_nxt = r_bidx - BIDX_W'(1);
      end
    end
  end

  // Extract the bit plane for the upcoming cycle from the next-state weights
  for (genvar gi = 0; gi < int'(LANES); gi++) begin : g_plane
    logic [WGT_W-1:0] w_lane;
    assign w_lane      = w_wgt_nxt[gi*WGT_W +: WGT_W];
    assign w_plane[gi] = w_lane[w_bidx_nxt];
  end

  b16_loom_psum_tree u_tree (
    .i_act_flat (w_act_nxt),
    .i_plane    (w_plane),
    .o_sum_c    (w_sum)
  );

  // Registered accumulator controls; outputs lead the operand registers by nothing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psum     <= '0;
      r_sel      <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_psum     <= (w_state_nxt == ST_RUN) ? w_sum : '0;
      r_sel      <= w_accept;
      r_done     <= (r_state == ST_RUN) && (r_bidx == '0);
      r_busy     <= (w_state_nxt == ST_RUN);
      r_in_ready <= (w_state_nxt == ST_IDLE) || (w_bidx_nxt == '0);
    end
  end

`ifdef LOOM_SIGNED_WGT_EN
  logic r_sign;

  // MSB plane of a two's-complement weight is subtracted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
    end else begin
      r_sign <= w_accept;
    end
  end

  assign bus.sign = r_sign;
`else
  assign bus.sign = 1'b0;
`endif

  assign bus.psum     = r_psum;
  assign bus.sel      = r_sel;
  assign bus.done     = r_done;
  assign bus.busy     = r_busy;
  assign bus.in_ready = r_in_ready;

endmodule
